// File: rtl/capture_frame_scheduler_if.sv
// capture_frame_scheduler_if: bundles the video timing, command, reader-lock
// and write-path signals of the capture frame scheduler.
// Signals:
//   vsync_n, de              video timing from the capture source
//   cmd_start/mode/stop      capture commands (one-cycle pulses)
//   rd_lock, rd_idx          buffer currently held by the readout side
//   capture_sig, wr_idx,     write-path enable, buffer index and byte base
//   wr_base
//   frame_done, done_idx,    publish pulse, newest valid buffer and its flag
//   done_valid
//   err_frame, busy,         bad-frame pulse, activity flag, publish counter
//   frame_cnt
// Modports: master = environment driving video/commands, slave = scheduler.
interface capture_frame_scheduler_if;
  logic        vsync_n;
  logic        de;
  logic        cmd_start;
  logic        cmd_mode;
  logic        cmd_stop;
  logic        rd_lock;
  logic [1:0]  rd_idx;
  logic        capture_sig;
  logic [1:0]  wr_idx;
  logic [31:0] wr_base;
  logic        frame_done;
  logic [1:0]  done_idx;
  logic        done_valid;
  logic        err_frame;
  logic        busy;
  logic [15:0] frame_cnt;

  modport master (
    output vsync_n, de, cmd_start, cmd_mode, cmd_stop, rd_lock, rd_idx,
    input  capture_sig, wr_idx, wr_base, frame_done, done_idx, done_valid,
           err_frame, busy, frame_cnt
  );

  modport slave (
    input  vsync_n, de, cmd_start, cmd_mode, cmd_stop, rd_lock, rd_idx,
    output capture_sig, wr_idx, wr_base, frame_done, done_idx, done_valid,
           err_frame, busy, frame_cnt
  );
endinterface

// File: rtl/capture_frame_scheduler.sv
// capture_frame_scheduler: sequences video-frame captures into a ring of DRAM
// frame buffers, validates each frame by its active line count and publishes
// the newest complete buffer while steering around the buffer the reader holds.
// Ports:
//   vid_clk  video clock, all logic on its rising edge
//   rst      synchronous, active-high reset
//   bus      capture_frame_scheduler_if.slave: timing/commands/reader lock in;
//            capture enable, write buffer index/base, publish and error
//            pulses, busy and published-frame counter out
module capture_frame_scheduler #(
  parameter int unsigned NUM_BUFS    = 3,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter logic [31:0] BUF_STRIDE  = 32'h0080_0000,
  parameter int unsigned FRAME_LINES = 900
) (
  input logic                      vid_clk,
  input logic                      rst,
  capture_frame_scheduler_if.slave bus
);
  localparam int unsigned IDX_W  = 2;
  localparam int unsigned LINE_W = 12;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned SUM_W  = 3;
  localparam logic [LINE_W-1:0] LINE_MAX  = '1;
  localparam logic [LINE_W-1:0] LINES_REQ = LINE_W'(FRAME_LINES);

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DRAIN} state_t;

  state_t             state_q;
  logic               mode_q;
  logic               capture_sig_q;
  logic               busy_q;
  logic [1:0]         vsync_q;
  logic [1:0]         de_q;
  logic [LINE_W-1:0]  line_cnt_q;
  logic [IDX_W-1:0]   wr_idx_q;
  logic [31:0]        wr_base_q;
  logic               frame_done_q;
  logic               err_frame_q;
  logic [IDX_W-1:0]   done_idx_q;
  logic               done_valid_q;
  logic [CNT_W-1:0]   frame_cnt_q;
  logic [IDX_W-1:0]   next_idx_d;

  logic fe_c;
  logic de_fall_c;
  logic counting_c;
  logic validate_c;
  logic frame_ok_c;

  // (idx + inc) mod NUM_BUFS; idx < NUM_BUFS <= 4 so one subtraction suffices
  function automatic logic [IDX_W-1:0] ring_add(input logic [IDX_W-1:0] idx,
                                                 input logic [SUM_W-1:0] inc);
    logic [SUM_W-1:0] s;
    s = SUM_W'(idx) + inc;
    if (s >= SUM_W'(NUM_BUFS)) s = s - SUM_W'(NUM_BUFS);
    return s[IDX_W-1:0];
  endfunction

  // Two-stage synchronizers; bit 0 is the newer sample
  always_ff @(posedge vid_clk) begin
    if (rst) begin
      vsync_q <= 2'b00;
      de_q    <= 2'b00;
    end else begin
      vsync_q <= {vsync_q[0], ~bus.vsync_n};
      de_q    <= {de_q[0], bus.de};
    end
  end

  assign fe_c       = (vsync_q == 2'b01);
  assign de_fall_c  = (de_q == 2'b10);
  assign counting_c = (state_q == CAPTURE) || (state_q == DRAIN);
  assign validate_c = fe_c && counting_c;
  assign frame_ok_c = (line_cnt_q == LINES_REQ);

  // Next write buffer: skip the locked one; fall back to reusing the current buffer
  always_comb begin
    next_idx_d = ring_add(wr_idx_q, SUM_W'(1));
    if (bus.rd_lock && (bus.rd_idx == next_idx_d)) begin
      next_idx_d = ring_add(wr_idx_q, SUM_W'(2));
      if (bus.rd_idx == next_idx_d) next_idx_d = wr_idx_q;
    end
  end

  // Capture sequencer, line counter and publish logic
  always_ff @(posedge vid_clk) begin
    if (rst) begin
      state_q       <= IDLE;
      mode_q        <= 1'b0;
      capture_sig_q <= 1'b0;
      busy_q        <= 1'b0;
      line_cnt_q    <= '0;
      wr_idx_q      <= '0;
      frame_done_q  <= 1'b0;
      err_frame_q   <= 1'b0;
      done_idx_q    <= '0;
      done_valid_q  <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      frame_done_q <= 1'b0;
      err_frame_q  <= 1'b0;

      if (counting_c && de_fall_c && (line_cnt_q != LINE_MAX))
        line_cnt_q <= line_cnt_q + LINE_W'(1);

      if (validate_c) begin
        if (frame_ok_c) begin
          frame_done_q <= 1'b1;
          done_idx_q   <= wr_idx_q;
          done_valid_q <= 1'b1;
          frame_cnt_q  <= frame_cnt_q + CNT_W'(1);
        end else begin
          err_frame_q <= 1'b1;
        end
      end

      case (state_q)
        IDLE: begin
          if (bus.cmd_start && !bus.cmd_stop) begin
            state_q       <= ARMED;
            capture_sig_q <= 1'b1;
            busy_q        <= 1'b1;
            mode_q        <= bus.cmd_mode;
          end
        end
        ARMED: begin
          if (bus.cmd_stop) begin
            state_q       <= IDLE;
            capture_sig_q <= 1'b0;
            busy_q        <= 1'b0;
          end else if (fe_c) begin
            // Write path samples capture_sig high at this edge, so single mode can drop it now
            state_q    <= CAPTURE;
            line_cnt_q <= '0;
            if (!mode_q) capture_sig_q <= 1'b0;
          end
        end
        CAPTURE: begin
          if (fe_c) begin
            line_cnt_q <= '0;
            if (!mode_q || bus.cmd_stop) begin
              state_q       <= IDLE;
              capture_sig_q <= 1'b0;
              busy_q        <= 1'b0;
            end else if (frame_ok_c) begin
              wr_idx_q <= next_idx_d;
            end
          end else if (bus.cmd_stop) begin
            state_q       <= DRAIN;
            capture_sig_q <= 1'b0;
          end
        end
        DRAIN: begin
          if (fe_c) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            line_cnt_q <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Buffer base follows wr_idx one cycle later and only moves when it does
  always_ff @(posedge vid_clk) begin
    if (rst) wr_base_q <= BASE_ADDR;
    else     wr_base_q <= BASE_ADDR + (32'(wr_idx_q) * BUF_STRIDE);
  end

  assign bus.capture_sig = capture_sig_q;
  assign bus.wr_idx      = wr_idx_q;
  assign bus.wr_base     = wr_base_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.done_idx    = done_idx_q;
  assign bus.done_valid  = done_valid_q;
  assign bus.err_frame   = err_frame_q;
  assign bus.busy        = busy_q;
  assign bus.frame_cnt   = frame_cnt_q;
endmodule

// File: tb/tb_capture_frame_scheduler.sv
// tb_capture_frame_scheduler: drives two schedulers (3 and 2 buffers) with the
// same video timing and commands and compares them against a frame-level model.
module tb_capture_frame_scheduler;
  localparam int NB[2] = '{3, 2};
  localparam logic [31:0] STRIDE = 32'h0080_0000;
  localparam int REQ_LINES = 900;
  localparam int ST_IDLE = 0, ST_ARMED = 1, ST_CAPT = 2, ST_DRAIN = 3;

  logic       vid_clk = 1'b0;
  logic       rst = 1'b1;
  logic       vsync_n = 1'b1;
  logic       de = 1'b0;
  logic       cmd_start = 1'b0;
  logic       cmd_mode = 1'b0;
  logic       cmd_stop = 1'b0;
  logic       rd_lock = 1'b0;
  logic [1:0] rd_idx = 2'd0;

  always #5 vid_clk = ~vid_clk;

  capture_frame_scheduler_if if3 ();
  capture_frame_scheduler_if if2 ();

  assign if3.vsync_n = vsync_n;   assign if2.vsync_n = vsync_n;
  assign if3.de = de;             assign if2.de = de;
  assign if3.cmd_start = cmd_start; assign if2.cmd_start = cmd_start;
  assign if3.cmd_mode = cmd_mode; assign if2.cmd_mode = cmd_mode;
  assign if3.cmd_stop = cmd_stop; assign if2.cmd_stop = cmd_stop;
  assign if3.rd_lock = rd_lock;   assign if2.rd_lock = rd_lock;
  assign if3.rd_idx = rd_idx;     assign if2.rd_idx = rd_idx;

  capture_frame_scheduler #(.NUM_BUFS(3)) dut3 (.vid_clk(vid_clk), .rst(rst), .bus(if3));
  capture_frame_scheduler #(.NUM_BUFS(2)) dut2 (.vid_clk(vid_clk), .rst(rst), .bus(if2));

  logic        o_cap[2], o_busy[2], o_dval[2];
  logic [1:0]  o_wr[2], o_didx[2];
  logic [31:0] o_base[2];
  logic [15:0] o_fcnt[2];
  assign o_cap[0] = if3.capture_sig;  assign o_cap[1] = if2.capture_sig;
  assign o_busy[0] = if3.busy;        assign o_busy[1] = if2.busy;
  assign o_dval[0] = if3.done_valid;  assign o_dval[1] = if2.done_valid;
  assign o_wr[0] = if3.wr_idx;        assign o_wr[1] = if2.wr_idx;
  assign o_didx[0] = if3.done_idx;    assign o_didx[1] = if2.done_idx;
  assign o_base[0] = if3.wr_base;     assign o_base[1] = if2.wr_base;
  assign o_fcnt[0] = if3.frame_cnt;   assign o_fcnt[1] = if2.frame_cnt;

  // Pulse monitor: every high cycle counts, so a stretched pulse shows up as extra
  int seen_done[2];
  int seen_err[2];
  int n_both;
  always @(negedge vid_clk) begin
    if (if3.frame_done) seen_done[0]++;
    if (if2.frame_done) seen_done[1]++;
    if (if3.err_frame) seen_err[0]++;
    if (if2.err_frame) seen_err[1]++;
    if ((if3.frame_done && if3.err_frame) || (if2.frame_done && if2.err_frame)) n_both++;
  end

  // Frame-level reference model
  int m_st[2], m_wr[2], m_didx[2], m_fcnt[2], m_ndone[2], m_nerr[2];
  bit m_mode[2], m_cap[2], m_dval[2];
  int m_lines;

  int n_assert = 0;
  int n_fail = 0;

  task automatic tick();
    @(posedge vid_clk);
    #1;
  endtask

  function automatic int pick_next(int wr, int nb, bit lock, int ridx);
    for (int s = 1; s <= 2; s++) begin
      if (!(lock && ridx == ((wr + s) % nb))) return (wr + s) % nb;
    end
    return wr;
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 2; k++) begin
      m_st[k] = ST_IDLE; m_wr[k] = 0; m_didx[k] = 0; m_fcnt[k] = 0;
      m_mode[k] = 1'b0; m_cap[k] = 1'b0; m_dval[k] = 1'b0;
    end
    m_lines = 0;
  endtask

  task automatic m_fe();
    int eff;
    bit ok;
    eff = (m_lines > 4095) ? 4095 : m_lines;
    ok = (eff == REQ_LINES);
    for (int k = 0; k < 2; k++) begin
      if (m_st[k] == ST_CAPT || m_st[k] == ST_DRAIN) begin
        if (ok) begin
          m_ndone[k]++; m_didx[k] = m_wr[k]; m_dval[k] = 1'b1;
          m_fcnt[k] = (m_fcnt[k] + 1) % 65536;
        end else begin
          m_nerr[k]++;
        end
        if (m_st[k] == ST_DRAIN || !m_mode[k]) begin
          m_st[k] = ST_IDLE; m_cap[k] = 1'b0;
        end else if (ok) begin
          m_wr[k] = pick_next(m_wr[k], NB[k], rd_lock, int'(rd_idx));
        end
      end else if (m_st[k] == ST_ARMED) begin
        m_st[k] = ST_CAPT;
        if (!m_mode[k]) m_cap[k] = 1'b0;
      end
    end
    m_lines = 0;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s.nb%0d.capture_sig", tag, NB[k]), 32'(o_cap[k]), 32'(m_cap[k]));
      chk($sformatf("%s.nb%0d.busy", tag, NB[k]), 32'(o_busy[k]), 32'(m_st[k] != ST_IDLE));
      chk($sformatf("%s.nb%0d.wr_idx", tag, NB[k]), 32'(o_wr[k]), 32'(m_wr[k]));
      chk($sformatf("%s.nb%0d.wr_base", tag, NB[k]), o_base[k], 32'(m_wr[k]) * STRIDE);
      chk($sformatf("%s.nb%0d.done_idx", tag, NB[k]), 32'(o_didx[k]), 32'(m_didx[k]));
      chk($sformatf("%s.nb%0d.done_valid", tag, NB[k]), 32'(o_dval[k]), 32'(m_dval[k]));
      chk($sformatf("%s.nb%0d.frame_cnt", tag, NB[k]), 32'(o_fcnt[k]), 32'(m_fcnt[k]));
      chk($sformatf("%s.nb%0d.done_pulses", tag, NB[k]), 32'(seen_done[k]), 32'(m_ndone[k]));
      chk($sformatf("%s.nb%0d.err_pulses", tag, NB[k]), 32'(seen_err[k]), 32'(m_nerr[k]));
    end
  endtask

  task automatic lines(int n);
    repeat (n) begin
      de = 1'b1; tick();
      de = 1'b0; tick();
    end
    tick();
    m_lines += n;
  endtask

  task automatic vsync();
    vsync_n = 1'b0; repeat (3) tick();
    vsync_n = 1'b1; repeat (3) tick();
    m_fe();
  endtask

  task automatic cmd(bit start, bit mode, bit stop);
    cmd_start = start; cmd_mode = mode; cmd_stop = stop;
    tick();
    cmd_start = 1'b0; cmd_mode = 1'b0; cmd_stop = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if (stop) begin
        if (m_st[k] == ST_ARMED) begin m_st[k] = ST_IDLE; m_cap[k] = 1'b0; end
        else if (m_st[k] == ST_CAPT) begin m_st[k] = ST_DRAIN; m_cap[k] = 1'b0; end
      end else if (start && m_st[k] == ST_IDLE) begin
        m_st[k] = ST_ARMED; m_cap[k] = 1'b1; m_mode[k] = mode;
      end
    end
  endtask

  initial begin
    m_reset();
    repeat (3) tick();
    check_all("reset_held");
    rst = 1'b0;
    tick();
    check_all("reset_released");

    // Single frame: only the first of two frames is captured
    cmd(1'b1, 1'b0, 1'b0);
    check_all("single_armed");
    vsync();
    check_all("single_fe1");
    lines(REQ_LINES);
    vsync();
    check_all("single_fe2");
    lines(REQ_LINES);
    vsync();
    check_all("single_done");

    // Continuous ring walk without lock
    cmd(1'b1, 1'b1, 1'b0);
    vsync();
    for (int f = 0; f < 3; f++) begin
      lines(REQ_LINES);
      vsync();
      check_all($sformatf("cont_f%0d", f));
    end

    // Reader holds buffer 1 while wr_idx is 0
    lines(REQ_LINES);
    rd_lock = 1'b1; rd_idx = 2'd1;
    vsync();
    check_all("lock_skip");
    rd_lock = 1'b0; rd_idx = 2'd0;

    // Short frame and a frame long enough to overflow an unsaturated counter
    lines(REQ_LINES - 1);
    vsync();
    check_all("short_frame");
    lines(4096 + REQ_LINES);
    vsync();
    check_all("saturate_frame");

    // Stop mid-capture drains the current frame
    lines(450);
    cmd(1'b0, 1'b0, 1'b1);
    check_all("stop_capture");
    lines(450);
    vsync();
    check_all("stop_drained");

    // Stop while armed, then simultaneous start/stop in IDLE
    cmd(1'b1, 1'b1, 1'b0);
    check_all("rearm");
    cmd(1'b0, 1'b0, 1'b1);
    check_all("stop_armed");
    vsync();
    check_all("stop_armed_fe");
    cmd(1'b1, 1'b1, 1'b1);
    check_all("start_stop_same");

    // Reset in the middle of a frame
    cmd(1'b1, 1'b1, 1'b0);
    vsync();
    lines(450);
    rst = 1'b1;
    tick();
    m_reset();
    check_all("rst_mid");
    rst = 1'b0;
    tick();
    lines(450);
    vsync();
    cmd(1'b1, 1'b1, 1'b0);
    vsync();
    lines(REQ_LINES);
    vsync();
    check_all("after_rst");

    // Randomized frames, commands and reader locks
    for (int it = 0; it < 16; it++) begin
      int sel, n, c;
      sel = int'($urandom_range(0, 3));
      if (sel < 2) n = REQ_LINES;
      else if (sel == 2) n = ($urandom_range(0, 1) == 1) ? REQ_LINES + 1 : REQ_LINES - 1;
      else n = int'($urandom_range(0, 30));
      c = int'($urandom_range(0, 7));
      lines(n / 2);
      if (c == 0) cmd(1'b0, 1'b0, 1'b1);
      else if (c == 1) cmd(1'b1, 1'($urandom_range(0, 1)), 1'b1);
      else if (c <= 4) cmd(1'b1, 1'($urandom_range(0, 1)), 1'b0);
      lines(n - n / 2);
      rd_lock = 1'($urandom_range(0, 1));
      rd_idx = 2'($urandom_range(0, 3));
      vsync();
      check_all($sformatf("rnd%0d", it));
    end

    chk("pulse_exclusive", 32'(n_both), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
